// File: rtl/ft232h_pkg.sv
// ft232h_pkg -- shared constants and types for the FT232H synchronous-FIFO
// transmit path.
//   DATA_W        : width of the ADBUS / AXIS byte lane
//   DEFAULT_DEPTH : default TX FIFO depth in bytes
//   byte_t        : one bus byte
package ft232h_pkg;

  localparam int DATA_W        = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef logic [DATA_W-1:0] byte_t;

endpackage

// File: rtl/ft232h_tx_fifo.sv
// ft232h_tx_fifo -- synchronous byte FIFO with an AXIS-style push side and a
// show-ahead pop side (head byte visible whenever not empty).
//   clk_i   : clock, rising edge
//   srst_i  : synchronous active-high reset, empties the FIFO
//   wdata_i : byte to push
//   push_i  : push request (accepted only while ready_o is high)
//   ready_o : registered "not full"
//   pop_i   : pop request (ignored while empty)
//   head_o  : current head byte (undefined content while empty)
//   empty_o : FIFO holds no bytes
module ft232h_tx_fifo
  import ft232h_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic  clk_i,
  input  logic  srst_i,
  input  byte_t wdata_i,
  input  logic  push_i,
  output logic  ready_o,
  input  logic  pop_i,
  output byte_t head_o,
  output logic  empty_o
);

  localparam int               AW         = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_COUNT = (AW+1)'(DEPTH);

  // Small depth: the head must be visible in the same cycle it becomes the
  // oldest entry, so the array is read asynchronously (distributed RAM).
  byte_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [AW:0]    count_q;
  logic [AW:0]    count_d;
  logic           ready_q;
  logic           push_ok;
  logic           pop_ok;

  // ready_q is !full, so a push can never land on a full FIFO and the
  // push/pop pair never conflicts.
  assign push_ok = push_i && ready_q;
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      // Registered from the next count so ready tracks the count exactly.
      ready_q <= (count_d != FULL_COUNT);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign ready_o = ready_q;

endmodule

// File: rtl/ft232h.sv
// ft232h -- transmit-only bridge from an AXI-Stream byte source to the FT232H
// synchronous 245 FIFO interface. Everything runs on ftdi_clk.
//   ftdi_clk          : 60 MHz clock from the chip
//   internal_fifo_rst : synchronous active-high reset
//   rxf_n             : chip RX-data flag (unused, TX only)
//   txe_n             : chip can accept a byte (active low)
//   rd_n, oe_n, siwu_n: held at 1
//   wr_n              : write strobe (active low), combinational
//   data              : ADBUS[7:0], always driven by this block
//   tdata/tvalid/tready : AXIS byte input
module ft232h
  import ft232h_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic              ftdi_clk,
  input  logic              internal_fifo_rst,
  input  logic              rxf_n,
  input  logic              txe_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic              siwu_n,
  output logic              oe_n,
  inout  wire  [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] tdata,
  input  logic              tvalid,
  output logic              tready
);

  logic  fifo_ready;
  logic  fifo_empty;
  logic  pop;
  byte_t head;
  logic  unused_rxf;

  assign unused_rxf = rxf_n;

  ft232h_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk_i   (ftdi_clk),
    .srst_i  (internal_fifo_rst),
    .wdata_i (tdata),
    .push_i  (tvalid),
    .ready_o (fifo_ready),
    .pop_i   (pop),
    .head_o  (head),
    .empty_o (fifo_empty)
  );

  // The strobe follows txe_n combinationally: when the chip deasserts txe_n
  // the strobe drops in the same cycle, so no byte is popped that the chip
  // would not capture. Reset also kills it immediately.
  assign pop  = !txe_n && !fifo_empty && !internal_fifo_rst;
  assign wr_n = !pop;

  // Masked by reset so the source sees "not ready" for the whole reset.
  assign tready = fifo_ready && !internal_fifo_rst;

  // FPGA owns the bus permanently; idle value is zero.
  assign data = (fifo_empty || internal_fifo_rst) ? '0 : head;

  assign rd_n   = 1'b1;
  assign oe_n   = 1'b1;
  assign siwu_n = 1'b1;

endmodule

// File: tb/tb_ft232h.sv
// tb_ft232h -- directed self-checking bench for ft232h. The chip side is
// modelled inline: it drives txe_n/rxf_n and captures data on every rising
// edge with wr_n=0 and txe_n=0.
module tb_ft232h;

  logic       clk;
  logic       rst;
  logic       rxf_n;
  logic       txe_n;
  logic       rd_n;
  logic       wr_n;
  logic       siwu_n;
  logic       oe_n;
  wire  [7:0] data;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] cap[$];

  ft232h #(
    .DEPTH (16)
  ) dut (
    .ftdi_clk          (clk),
    .internal_fifo_rst (rst),
    .rxf_n             (rxf_n),
    .txe_n             (txe_n),
    .rd_n              (rd_n),
    .wr_n              (wr_n),
    .siwu_n            (siwu_n),
    .oe_n              (oe_n),
    .data              (data),
    .tdata             (tdata),
    .tvalid            (tvalid),
    .tready            (tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chip-side capture.
  always @(posedge clk) begin
    if (!txe_n && !wr_n) cap.push_back(data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Stream bytes start, start+1, ... with txe_n=1 until the FIFO blocks.
  task automatic fill(input int start);
    int acc = 0;
    bit took;
    @(negedge clk);
    txe_n  = 1'b1;
    tvalid = 1'b1;
    tdata  = 8'(start);
    repeat (24) begin
      #1;
      took = tready;
      if (took) acc++;
      if (wr_n !== 1'b1) check("fill_wr_n_low", wr_n, 1);
      @(negedge clk);
      if (took) tdata = tdata + 8'd1;
    end
    tvalid = 1'b0;
    #1;
    check("fill_count", acc, 16);
    check("fill_next_tdata", tdata, (start + 16) & 255);
    check("fill_tready", tready, 0);
    check("fill_wr_n", wr_n, 1);
    check("fill_head", data, start);
  endtask

  // Drain 16 bytes; txe_n is held high for gap_len cycles after gap_after bytes.
  task automatic drain(input int start, input int gap_after, input int gap_len);
    int idx  = 0;
    int gaps = gap_len;
    int cyc  = 0;
    cap.delete();
    while (idx < 16 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (idx == gap_after && gaps > 0) begin
        txe_n = 1'b1;
        gaps--;
      end else begin
        txe_n = 1'b0;
      end
      #1;
      if (txe_n) begin
        check("gap_wr_n", wr_n, 1);
        check("gap_data", data, start + idx);
      end else begin
        check($sformatf("burst_wr_n_%0d", idx), wr_n, 0);
        check($sformatf("burst_data_%0d", idx), data, start + idx);
        idx++;
      end
    end
    check("drain_len", idx, 16);
    @(negedge clk);
    #1;
    check("drain_end_wr_n", wr_n, 1);
    check("drain_end_data", data, 0);
    check("drain_end_tready", tready, 1);
    txe_n = 1'b1;
    check("cap_len", cap.size(), 16);
    for (int i = 0; i < cap.size(); i++) begin
      check($sformatf("cap_%0d", i), cap[i], start + i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst    = 1'b1;
    rxf_n  = 1'b1;
    txe_n  = 1'b1;
    tvalid = 1'b0;
    tdata  = 8'h00;

    // Reset held three cycles.
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst_ctrl", {wr_n, rd_n, oe_n, siwu_n, tready}, 5'b11110);
      check("rst_data", data, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_tready_now", tready, 0);
    @(negedge clk);
    #1;
    check("rel_tready_next", tready, 1);
    check("rel_wr_n", wr_n, 1);

    // Fill to full, then a straight burst.
    fill(69);
    drain(69, 0, 0);

    // Same again with txe_n high for two cycles after the fifth byte.
    fill(69);
    drain(69, 5, 2);

    // Second burst with fresh values.
    fill(85);
    drain(85, 0, 0);

    // One byte buffered, then push and pop in the same cycle.
    @(negedge clk);
    txe_n  = 1'b1;
    tvalid = 1'b1;
    tdata  = 8'hA5;
    @(negedge clk);
    tvalid = 1'b0;
    #1;
    check("one_wr_n", wr_n, 1);
    check("one_data", data, 8'hA5);
    cap.delete();
    @(negedge clk);
    txe_n  = 1'b0;
    tvalid = 1'b1;
    tdata  = 8'h5A;
    #1;
    check("pp_tready", tready, 1);
    check("pp_wr_n", wr_n, 0);
    check("pp_data", data, 8'hA5);
    @(negedge clk);
    txe_n  = 1'b1;
    tvalid = 1'b0;
    #1;
    check("pp_after_wr_n", wr_n, 1);
    check("pp_after_data", data, 8'h5A);
    check("pp_after_tready", tready, 1);
    @(negedge clk);
    txe_n = 1'b0;
    #1;
    check("pp_last_wr_n", wr_n, 0);
    check("pp_last_data", data, 8'h5A);
    @(negedge clk);
    txe_n = 1'b1;
    #1;
    check("pp_empty_data", data, 0);
    check("pp_cap_len", cap.size(), 2);
    if (cap.size() == 2) begin
      check("pp_cap_0", cap[0], 8'hA5);
      check("pp_cap_1", cap[1], 8'h5A);
    end

    // Reset in the middle of a burst.
    fill(16);
    cap.delete();
    repeat (3) begin
      @(negedge clk);
      txe_n = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_wr_n", wr_n, 1);
    check("mid_rst_data", data, 0);
    check("mid_rst_tready", tready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      check("post_rst_wr_n", wr_n, 1);
      check("post_rst_data", data, 0);
    end
    check("post_rst_tready", tready, 1);
    check("post_rst_ties", {rd_n, oe_n, siwu_n}, 3'b111);
    check("mid_cap_len", cap.size(), 3);
    for (int i = 0; i < cap.size(); i++) begin
      check($sformatf("mid_cap_%0d", i), cap[i], 16 + i);
    end
    txe_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ft232h.md
FT232H -- requirements
Module: ft232h

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning TX FIFO depth in bytes (power of two, >=2).
REQ-002 SHALL have port ftdi_clk  input  1  the single clock (60 MHz from the FT232H); all logic is on its rising edge.
REQ-003 SHALL have port internal_fifo_rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rxf_n  input  1  chip has RX data (active low); ignored, TX-only block.
REQ-005 SHALL have port txe_n  input  1  chip can accept a byte (active low).
REQ-006 SHALL have port rd_n  output  1  read strobe, tied 1.
REQ-007 SHALL have port wr_n  output  1  write strobe (active low).
REQ-008 SHALL have port siwu_n  output  1  send-immediate, tied 1.
REQ-009 SHALL have port oe_n  output  1  chip output enable, tied 1 (FPGA owns the bus).
REQ-010 SHALL have port data  inout  8  ADBUS[7:0], always driven by this block.
REQ-011 SHALL have port tdata  input  8  AXI-Stream byte in.
REQ-012 SHALL have port tvalid  input  1  AXIS valid.
REQ-013 SHALL have port tready  output  1  AXIS ready.
REQ-014 SHALL treat the upstream AXIS source as synchronous to ftdi_clk; any clock-domain crossing is outside this block.

Function
REQ-015 SHALL buffer bytes in a DEPTH-entry FIFO; a byte is pushed on a rising edge where tvalid && tready.
REQ-016 SHALL drive tready = registered !full; tready is 0 when the FIFO holds DEPTH bytes.
REQ-017 SHALL drive wr_n = !(!txe_n && !empty && !internal_fifo_rst) combinationally, so that wr_n rises in the same cycle txe_n rises.
REQ-018 SHALL drive data with the FIFO head byte when not empty, and 8'h00 when empty.
REQ-019 SHALL pop the head byte on every rising edge where wr_n == 0, giving one byte per cycle during a burst.
REQ-020 SHALL neither drop nor duplicate a byte when txe_n toggles mid-burst; bytes leave in push order.
REQ-021 SHALL perform push and pop in the same cycle when both are enabled, leaving the count unchanged.
REQ-022 SHALL block a push while full; tready is 0 in that case, so the push and pop conditions never conflict.
REQ-023 SHALL wrap read and write pointers modulo DEPTH, and derive full/empty from a log2(DEPTH)+1-bit count or extra pointer bit.
REQ-024 SHALL hold rd_n, oe_n and siwu_n at constant 1 and never tri-state data.

Reset
REQ-025 SHALL, while internal_fifo_rst=1, empty the FIFO and drive tready=0, wr_n=1, data=8'h00, rd_n=1, oe_n=1, siwu_n=1.
REQ-026 SHALL raise tready one cycle after reset is released.
REQ-027 SHALL discard buffered bytes on reset mid-burst, raising wr_n on the same cycle.

Structure
REQ-028 SHALL place the constant DATA_W=8 and the default depth in package ft232h_pkg.
REQ-029 SHALL implement the buffer as sub-module ft232h_tx_fifo (synchronous FIFO, AXIS-style push, show-ahead pop).
REQ-030 SHALL be verified against the chip model ft232h_bfm, which generates ftdi_clk, drives txe_n/rxf_n, captures a byte on each edge with wr_n=0 and txe_n=0, and presents captured bytes on a PC-side AXIS (tdata/tvalid/tready).

Verification
REQ-031 Reset held 3 cycles -> wr_n=rd_n=oe_n=siwu_n=1 and tready=0 during reset; tready=1 one cycle after release.
REQ-032 txe_n=1, stream bytes 69,70,... with tvalid=1 -> exactly 16 bytes accepted (69..84), then tready=0 and wr_n stays 1.
REQ-033 After the fill, txe_n=0 -> wr_n low for 16 consecutive cycles, data=69..84 in order, then wr_n=1 and tready=1; bfm outputs 69..84.
REQ-034 Drain with txe_n forced high for 2 cycles after the 5th byte -> wr_n high in those cycles; bfm receives 69..84 with no gap or duplicate.
REQ-035 Second burst after the drain (85..100) -> bfm receives 85..100 in order.
REQ-036 One byte buffered, push and pop in the same cycle -> count stays 1; reset asserted mid-drain -> wr_n=1 that cycle and no further bytes are emitted.
